// File: rtl/sbus_arbiter.sv
// Two-requester sbus arbiter: dbus has priority, a starvation counter bounds ibus wait,
// and an owner lock holds mbus for the full duration of a stalled access.
module sbus_arbiter #(
  parameter int STARVE_LIMIT = 4,
  parameter int CNT_W        = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  // fetch requester
  input  logic             i_ibus_en,
  input  logic             i_ibus_we,
  input  logic [1:0]       i_ibus_size,
  input  logic [31:0]      i_ibus_addr,
  input  logic [31:0]      i_ibus_data_w,
  output logic [31:0]      o_ibus_data_r,
  output logic             o_ibus_stall,
  // data requester
  input  logic             i_dbus_en,
  input  logic             i_dbus_we,
  input  logic [1:0]       i_dbus_size,
  input  logic [31:0]      i_dbus_addr,
  input  logic [31:0]      i_dbus_data_w,
  output logic [31:0]      o_dbus_data_r,
  output logic             o_dbus_stall,
  // shared memory port
  output logic             o_mbus_en,
  output logic             o_mbus_we,
  output logic [1:0]       o_mbus_size,
  output logic [31:0]      o_mbus_addr,
  output logic [31:0]      o_mbus_data_w,
  input  logic [31:0]      i_mbus_data_r,
  input  logic             i_mbus_stall,
  // observation: 0 = idle, 1 = ibus owns, 2 = dbus owns
  output logic [1:0]       o_owner,
  output logic [CNT_W-1:0] o_starve_cnt
);

  typedef enum logic [1:0] {IDLE = 2'd0, OWN_I = 2'd1, OWN_D = 2'd2} state_t;
  typedef enum logic [1:0] {SEL_NONE = 2'd0, SEL_I = 2'd1, SEL_D = 2'd2} sel_t;

  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

  state_t           r_state;
  state_t           w_state_nxt;
  logic [CNT_W-1:0] r_starve_cnt;
  logic [CNT_W-1:0] w_starve_nxt;
  sel_t             w_sel;
  logic             w_starved;

  assign w_starved = i_ibus_en && (r_starve_cnt >= LIMIT);

  // Selection is gated by rst_n so mbus.en drops asynchronously with reset.
  always_comb begin
    w_sel = SEL_NONE;
    if (rst_n) begin
      case (r_state)
        IDLE: begin
          if (i_dbus_en && !w_starved) w_sel = SEL_D;
          else if (i_ibus_en)          w_sel = SEL_I;
        end
        OWN_I:   if (i_ibus_en) w_sel = SEL_I;
        OWN_D:   if (i_dbus_en) w_sel = SEL_D;
        default: w_sel = SEL_NONE;
      endcase
    end
  end

  always_comb begin
    o_mbus_en     = 1'b0;
    o_mbus_we     = 1'b0;
    o_mbus_size   = 2'd0;
    o_mbus_addr   = 32'h0;
    o_mbus_data_w = 32'h0;
    o_ibus_data_r = 32'h0;
    o_dbus_data_r = 32'h0;
    o_ibus_stall  = i_ibus_en;
    o_dbus_stall  = i_dbus_en;
    case (w_sel)
      SEL_I: begin
        o_mbus_en     = 1'b1;
        o_mbus_we     = i_ibus_we;
        o_mbus_size   = i_ibus_size;
        o_mbus_addr   = i_ibus_addr;
        o_mbus_data_w = i_ibus_data_w;
        o_ibus_data_r = i_mbus_data_r;
        o_ibus_stall  = i_mbus_stall;
      end
      SEL_D: begin
        o_mbus_en     = 1'b1;
        o_mbus_we     = i_dbus_we;
        o_mbus_size   = i_dbus_size;
        o_mbus_addr   = i_dbus_addr;
        o_mbus_data_w = i_dbus_data_w;
        o_dbus_data_r = i_mbus_data_r;
        o_dbus_stall  = i_mbus_stall;
      end
      default: ;
    endcase
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE: begin
        if (w_sel == SEL_I && i_mbus_stall)      w_state_nxt = OWN_I;
        else if (w_sel == SEL_D && i_mbus_stall) w_state_nxt = OWN_D;
      end
      // A dropped en while owning is a protocol violation; release the lock.
      OWN_I:   if (!i_ibus_en || !i_mbus_stall) w_state_nxt = IDLE;
      OWN_D:   if (!i_dbus_en || !i_mbus_stall) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_comb begin
    w_starve_nxt = r_starve_cnt;
    if (!i_ibus_en) begin
      w_starve_nxt = '0;
    end else if (w_sel == SEL_I) begin
      if (!i_mbus_stall) w_starve_nxt = '0;
    end else if (r_starve_cnt < LIMIT) begin
      w_starve_nxt = r_starve_cnt + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= IDLE;
      r_starve_cnt <= '0;
    end else begin
      r_state      <= w_state_nxt;
      r_starve_cnt <= w_starve_nxt;
    end
  end

  assign o_owner      = r_state;
  assign o_starve_cnt = r_starve_cnt;

endmodule

// File: tb/tb_sbus_arbiter.sv
// Directed + randomized bench for sbus_arbiter against a requester-level reference model.
module tb_sbus_arbiter;

  localparam int LIMIT = 4;

  logic        clk;
  logic        rst_n;
  logic        ibus_en, ibus_we, dbus_en, dbus_we;
  logic [1:0]  ibus_size, dbus_size;
  logic [31:0] ibus_addr, ibus_data_w, dbus_addr, dbus_data_w;
  logic [31:0] ibus_data_r, dbus_data_r;
  logic        ibus_stall, dbus_stall;
  logic        mbus_en, mbus_we;
  logic [1:0]  mbus_size;
  logic [31:0] mbus_addr, mbus_data_w, mbus_data_r;
  logic        mbus_stall;
  logic [1:0]  owner;
  logic [2:0]  starve_cnt;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: who holds the memory (0 none, 1 fetch, 2 data) and
  // how many consecutive cycles the fetch side has been passed over.
  int m_holder = 0;
  int m_passed = 0;
  logic i_hold, d_hold;

  sbus_arbiter #(.STARVE_LIMIT(LIMIT), .CNT_W(3)) dut (
    .clk(clk), .rst_n(rst_n),
    .i_ibus_en(ibus_en), .i_ibus_we(ibus_we), .i_ibus_size(ibus_size),
    .i_ibus_addr(ibus_addr), .i_ibus_data_w(ibus_data_w),
    .o_ibus_data_r(ibus_data_r), .o_ibus_stall(ibus_stall),
    .i_dbus_en(dbus_en), .i_dbus_we(dbus_we), .i_dbus_size(dbus_size),
    .i_dbus_addr(dbus_addr), .i_dbus_data_w(dbus_data_w),
    .o_dbus_data_r(dbus_data_r), .o_dbus_stall(dbus_stall),
    .o_mbus_en(mbus_en), .o_mbus_we(mbus_we), .o_mbus_size(mbus_size),
    .o_mbus_addr(mbus_addr), .o_mbus_data_w(mbus_data_w),
    .i_mbus_data_r(mbus_data_r), .i_mbus_stall(mbus_stall),
    .o_owner(owner), .o_starve_cnt(starve_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Who gets the memory this cycle according to the arbitration rules.
  function automatic int model_grant();
    bit fetch_starved;
    if (!rst_n) return 0;
    if (m_holder != 0) begin
      if (m_holder == 1) return ibus_en ? 1 : 0;
      return dbus_en ? 2 : 0;
    end
    fetch_starved = ibus_en && (m_passed >= LIMIT);
    if (dbus_en && !fetch_starved) return 2;
    if (ibus_en) return 1;
    return 0;
  endfunction

  task automatic cycle(input string tag);
    int g;
    int nh, np;
    #1;
    g = model_grant();
    check({tag, ".mbus_en"}, {31'd0, mbus_en}, {31'd0, g != 0});
    check({tag, ".owner"}, {30'd0, owner}, m_holder);
    check({tag, ".starve"}, {29'd0, starve_cnt}, m_passed);
    if (g == 1) begin
      check({tag, ".maddr"}, mbus_addr, ibus_addr);
      check({tag, ".mwdata"}, mbus_data_w, ibus_data_w);
      check({tag, ".mctl"}, {29'd0, mbus_we, mbus_size}, {29'd0, ibus_we, ibus_size});
    end else if (g == 2) begin
      check({tag, ".maddr"}, mbus_addr, dbus_addr);
      check({tag, ".mwdata"}, mbus_data_w, dbus_data_w);
      check({tag, ".mctl"}, {29'd0, mbus_we, mbus_size}, {29'd0, dbus_we, dbus_size});
    end
    check({tag, ".istall"}, {31'd0, ibus_stall}, {31'd0, (g == 1) ? mbus_stall : ibus_en});
    check({tag, ".dstall"}, {31'd0, dbus_stall}, {31'd0, (g == 2) ? mbus_stall : dbus_en});
    check({tag, ".irdata"}, ibus_data_r, (g == 1) ? mbus_data_r : 32'h0);
    check({tag, ".drdata"}, dbus_data_r, (g == 2) ? mbus_data_r : 32'h0);
    i_hold = ibus_en && ibus_stall;
    d_hold = dbus_en && dbus_stall;
    nh = 0;
    np = 0;
    if (rst_n) begin
      nh = (g != 0 && mbus_stall) ? g : 0;
      if (!ibus_en)    np = 0;
      else if (g == 1) np = mbus_stall ? m_passed : 0;
      else             np = (m_passed < LIMIT) ? m_passed + 1 : m_passed;
    end
    @(posedge clk);
    #1;
    m_holder = nh;
    m_passed = np;
  endtask

  task automatic set_i(input logic en, input logic we, input logic [31:0] addr);
    ibus_en = en; ibus_we = we; ibus_addr = addr;
    ibus_size = 2'd2; ibus_data_w = $urandom;
  endtask

  task automatic set_d(input logic en, input logic we, input logic [31:0] addr);
    dbus_en = en; dbus_we = we; dbus_addr = addr;
    dbus_size = 2'(addr[1:0]); dbus_data_w = $urandom;
  endtask

  initial begin
    rst_n = 1'b0;
    set_i(1'b1, 1'b0, 32'hBFC00000);
    set_d(1'b1, 1'b1, 32'h80000000);
    mbus_stall = 1'b0;
    mbus_data_r = 32'h1234_5678;

    // 1: reset with both requesting, then dbus is granted first
    #2;
    check("t1.rst_mbus_en", {31'd0, mbus_en}, 32'd0);
    check("t1.rst_istall", {31'd0, ibus_stall}, 32'd1);
    check("t1.rst_dstall", {31'd0, dbus_stall}, 32'd1);
    cycle("t1.rst");
    rst_n = 1'b1;
    #1;
    check("t1.grant_d", mbus_addr, 32'h80000000);
    cycle("t1.run");
    set_i(1'b0, 1'b0, 32'h0);
    set_d(1'b0, 1'b0, 32'h0);
    cycle("t1.idle");

    // 2: ibus alone, single-cycle access
    set_i(1'b1, 1'b0, 32'hBFC00000);
    mbus_data_r = 32'hCAFE_F00D;
    #1;
    check("t2.irdata", ibus_data_r, 32'hCAFE_F00D);
    check("t2.istall", {31'd0, ibus_stall}, 32'd0);
    cycle("t2.a");
    check("t2.owner_idle", {30'd0, owner}, 32'd0);
    set_i(1'b0, 1'b0, 32'h0);
    cycle("t2.b");

    // 3: dbus store locked for 3 stalled cycles, ibus arrives mid-way
    set_d(1'b1, 1'b1, 32'h80001000);
    mbus_stall = 1'b1;
    cycle("t3.s1");
    set_i(1'b1, 1'b0, 32'hBFC00040);
    cycle("t3.s2");
    check("t3.addr_stable", mbus_addr, 32'h80001000);
    check("t3.istall", {31'd0, ibus_stall}, 32'd1);
    cycle("t3.s3");
    mbus_stall = 1'b0;
    cycle("t3.done");
    set_d(1'b0, 1'b0, 32'h0);
    #1;
    check("t3.i_granted", mbus_addr, 32'hBFC00040);
    cycle("t3.iserve");
    set_i(1'b0, 1'b0, 32'h0);
    cycle("t3.idle");

    // 4: continuous contention with single-cycle memory
    set_i(1'b1, 1'b0, 32'hBFC00100);
    set_d(1'b1, 1'b0, 32'h80002000);
    for (int k = 0; k < 5; k++) begin
      #1;
      check($sformatf("t4.win%0d", k), mbus_addr, (k < 4) ? 32'h80002000 : 32'hBFC00100);
      cycle($sformatf("t4.c%0d", k));
    end
    check("t4.starve_clr", {29'd0, starve_cnt}, 32'd0);
    set_i(1'b0, 1'b0, 32'h0);
    set_d(1'b0, 1'b0, 32'h0);
    cycle("t4.idle");

    // 5: asynchronous reset while ibus owns a stalled access
    set_i(1'b1, 1'b0, 32'hBFC00200);
    mbus_stall = 1'b1;
    cycle("t5.grant");
    cycle("t5.own");
    check("t5.owner_i", {30'd0, owner}, 32'd1);
    rst_n = 1'b0;
    #1;
    check("t5.mbus_en", {31'd0, mbus_en}, 32'd0);
    check("t5.owner", {30'd0, owner}, 32'd0);
    check("t5.starve", {29'd0, starve_cnt}, 32'd0);
    m_holder = 0;
    m_passed = 0;
    cycle("t5.inrst");
    rst_n = 1'b1;
    set_i(1'b0, 1'b0, 32'h0);
    mbus_stall = 1'b0;
    cycle("t5.idle");

    // 6: dbus drops en while owning; pending ibus then served
    set_d(1'b1, 1'b0, 32'h80003000);
    set_i(1'b1, 1'b0, 32'hBFC00300);
    mbus_stall = 1'b1;
    cycle("t6.grant");
    set_d(1'b0, 1'b0, 32'h0);
    #1;
    check("t6.drop_en", {31'd0, mbus_en}, 32'd0);
    cycle("t6.drop");
    mbus_stall = 1'b0;
    #1;
    check("t6.iserve", mbus_addr, 32'hBFC00300);
    check("t6.istall", {31'd0, ibus_stall}, 32'd0);
    cycle("t6.iserve_c");
    set_i(1'b0, 1'b0, 32'h0);
    cycle("t6.idle");

    // Randomized traffic obeying the hold-while-stalled rule
    i_hold = 1'b0;
    d_hold = 1'b0;
    for (int n = 0; n < 400; n++) begin
      if (!i_hold) set_i($urandom_range(0, 2) != 0, 1'b0, {$urandom} & 32'hFFFF_FFFC);
      if (!d_hold) set_d($urandom_range(0, 1) != 0, 1'($urandom), $urandom);
      mbus_stall  = ($urandom_range(0, 4) < 2);
      mbus_data_r = $urandom;
      cycle($sformatf("rnd%0d", n));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
